lif_neuron_array: RTL and testbench
===================================

// Module: lif_neuron_array
// PURPOSE
//  Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons sharing one update datapath.
//  Each start pulse (one network timestep) scans all neurons, one per cycle, updating potential/refractory
//  state held in internal registers; the spike vector is published atomically with a done pulse.
//  Sits between the synaptic-current accumulator and the spike router in the SNN core.
// PARAMETERS
//  NUM_NEURONS  4  neurons in the array (>=2)
//  W            5  signed width of potential, current, threshold (two's complement)
//  REF_W        5  width of refractory period/counter
//  IDX_W        $clog2(NUM_NEURONS)  neuron index width (derived)
// PORTS
//  clk                 in   1              clock, rising edge
//  reset               in   1              asynchronous, active-high
//  start               in   1              1-cycle pulse: begin a timestep scan; ignored while busy
//  input_current       in   NUM_NEURONS*W  per-neuron signed current, neuron i at [i*W +: W]
//  threshold           in   W              signed firing threshold, shared (>0 required)
//  decay_shift         in   3              leak = V>>>decay_shift; 0 = no leak; >=W treated as leak 0
//  refractory_period   in   REF_W          refractory timesteps after a spike
//  reset_mode          in   1              0 = subtract threshold on spike, 1 = reset potential to 0
//  busy                out  1              high while scanning
//  done                out  1              1-cycle pulse when spikes_out is updated
//  spikes_out          out  NUM_NEURONS    spike vector of last completed timestep, held until next done
//  dbg_sel             in   IDX_W          debug neuron select
//  dbg_potential       out  W              combinational read of potential[dbg_sel]
// BEHAVIOUR
//  Reset: all potentials, refractory counters, spikes_out, shadow spikes = 0; busy=0, done=0; FSM IDLE.
//  FSM: IDLE --start--> RUN(idx=0); RUN processes neuron idx each cycle, idx++; after idx=N-1 -> DONE;
//   DONE: spikes_out <= shadow, done=1 for one cycle -> IDLE. start->done latency = NUM_NEURONS+1 cycles.
//  busy=1 in RUN and DONE. start in RUN/DONE is ignored (no queueing). start in IDLE same cycle as done
//   impossible (DONE precedes IDLE); back-to-back start accepted the cycle after done.
//  Inputs for neuron i are sampled in its RUN cycle; all inputs must be stable from start to done.
//  Per-neuron update (V = current potential, R = refractory counter, all signed W+2 intermediate):
//   leak = (decay_shift==0 || decay_shift>=W) ? 0 : V>>>decay_shift (arithmetic shift).
//   nxt  = V - leak + (R==0 ? I : 0);  R>0 -> R <= R-1.
//   nxt saturated to [-2^(W-1), 2^(W-1)-1].
//   Fire check on pre-update V: if V >= threshold (signed) -> shadow[i]=1; V <= reset_mode ? 0 : V-threshold;
//    R <= refractory_period (overrides decrement and nxt). Else shadow[i]=0; V <= sat(nxt).
//   Fire is allowed while R>0 (residual potential above threshold still fires).
//  refractory_period=0: neuron integrates again next timestep. threshold<=0: undefined, not checked.
//  Async reset mid-scan: abort immediately, no done pulse, all state cleared as above.
//  dbg_potential reflects register contents (updated value visible cycle after neuron's RUN slot).
// STRUCTURE
//  Package lif_pkg: FSM state enum (IDLE, RUN, DONE), sat_lo/sat_hi functions of W, leak function.
//  Sub-module lif_update_core: combinational single-neuron datapath (V, R, I, threshold, decay_shift,
//   reset_mode -> V_next, R_next, spike); instantiated once, muxed by idx.
//  State storage: flop arrays potential[NUM_NEURONS], refr[NUM_NEURONS], shadow spike vector.
// TESTING (W=5, NUM_NEURONS=4, REF_W=5)
//  1 Latency: start pulse -> busy for 5 cycles, done exactly 5 cycles after start; start mid-scan ignored.
//  2 Integrate/fire: I=3 all, thr=8, shift=0, ref=0, mode 0 -> V=3,6,9; spike at step 4, V=1 after.
//  3 Leak+saturate: I=15, shift=1 -> V caps at 15 never wraps; I=-16 -> V floors at -16; shift=1 from V=8,I=0 -> 4.
//  4 Refractory: ref=2, thr=4, I=5 -> spike step 2, next 2 steps I ignored (leak only), integrates step 5.
//  5 Reset mode: V=9 at fire with thr=8 -> mode0 V=1, mode1 V=0; per-neuron different I gives independent spikes.
//  6 Async reset during RUN idx=2 -> busy/done 0, spikes_out 0, all dbg_potential 0; next start runs clean.

Source files
------------

// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg: shared types and arithmetic helpers for the LIF neuron array (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

package lif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  // Shift amounts of zero or at/above the datapath width disable the leak.
  function automatic int leak(input int v, input int shift, input int w);
    if (shift == 0 || shift >= w) return 0;
    return v >>> shift;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lif_update_core.sv
// -----------------------------------------------------------------------------
// lif_update_core: combinational single-neuron leak/integrate/fire step (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module lif_update_core
  import lif_pkg::*;
#(
  parameter int W     = 5,
  parameter int REF_W = 5
) (
  input  logic signed [W-1:0]     potential,
  input  logic        [REF_W-1:0] refr,
  input  logic signed [W-1:0]     current,
  input  logic signed [W-1:0]     threshold,
  input  logic        [2:0]       decay_shift,
  input  logic        [REF_W-1:0] refractory_period,
  input  logic                    reset_mode,
  output logic signed [W-1:0]     potential_next,
  output logic        [REF_W-1:0] refr_next,
  output logic                    spike
);

  localparam logic signed [W+1:0] HI = (W + 2)'(sat_hi(W));
  localparam logic signed [W+1:0] LO = (W + 2)'(sat_lo(W));

  logic signed [W+1:0] v_ext;
  logic signed [W+1:0] cur_ext;
  logic signed [W+1:0] leak_v;
  logic signed [W+1:0] nxt;

  always_comb begin
    v_ext   = {{2{potential[W-1]}}, potential};
    cur_ext = (refr == '0) ? {{2{current[W-1]}}, current} : '0;
    leak_v  = (W + 2)'(leak(int'(potential), int'(decay_shift), W));
    nxt     = v_ext - leak_v + cur_ext;

    // Firing is judged on the pre-update potential and overrides integration.
    if (potential >= threshold) begin
      spike          = 1'b1;
      potential_next = reset_mode ? '0 : potential - threshold;
      refr_next      = refractory_period;
    end else begin
      spike = 1'b0;
      if (nxt > HI)
        potential_next = HI[W-1:0];
      else if (nxt < LO)
        potential_next = LO[W-1:0];
      else
        potential_next = nxt[W-1:0];
      refr_next = (refr != '0) ? refr - REF_W'(1) : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lif_neuron_array.sv
// -----------------------------------------------------------------------------
// lif_neuron_array: time-multiplexed leaky integrate-and-fire array (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int W           = 5,
  parameter int REF_W       = 5,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_NEURONS*W-1:0] input_current,
  input  logic signed [W-1:0]      threshold,
  input  logic [2:0]               decay_shift,
  input  logic [REF_W-1:0]         refractory_period,
  input  logic                     reset_mode,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_NEURONS-1:0]   spikes_out,
  input  logic [IDX_W-1:0]         dbg_sel,
  output logic signed [W-1:0]      dbg_potential
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic signed [W-1:0]     potential [NUM_NEURONS];
  logic [REF_W-1:0]        refr      [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]  shadow;
  logic [NUM_NEURONS-1:0]  shadow_merged;

  logic signed [W-1:0]     cur;
  logic signed [W-1:0]     potential_next;
  logic [REF_W-1:0]        refr_next;
  logic                    spike;

  assign cur           = input_current[int'(idx)*W +: W];
  assign dbg_potential = potential[dbg_sel];

  lif_update_core #(
    .W     (W),
    .REF_W (REF_W)
  ) u_core (
    .potential         (potential[idx]),
    .refr              (refr[idx]),
    .current           (cur),
    .threshold         (threshold),
    .decay_shift       (decay_shift),
    .refractory_period (refractory_period),
    .reset_mode        (reset_mode),
    .potential_next    (potential_next),
    .refr_next         (refr_next),
    .spike             (spike)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shadow_merged      = shadow;
    shadow_merged[idx] = spike;
  end

  // The vector is published on entry to DONE so it is already valid while done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      shadow     <= '0;
      spikes_out <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        potential[n] <= '0;
        refr[n]      <= '0;
      end
    end else if (state == RUN) begin
      potential[idx] <= potential_next;
      refr[idx]      <= refr_next;
      shadow         <= shadow_merged;
      idx            <= idx + IDX_W'(1);
      if (idx == LAST) spikes_out <= shadow_merged;
    end else if (state == IDLE && start) begin
      idx <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_array: scoreboard bench for the LIF neuron array (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module tb_lif_neuron_array;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int RW = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [N*W-1:0]      input_current;
  logic signed [W-1:0] threshold;
  logic [2:0]          decay_shift;
  logic [RW-1:0]       refractory_period;
  logic                reset_mode;
  logic                busy;
  logic                done;
  logic [N-1:0]        spikes_out;
  logic [1:0]          dbg_sel;
  logic signed [W-1:0] dbg_potential;

  lif_neuron_array #(
    .NUM_NEURONS (N),
    .W           (W),
    .REF_W       (RW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .input_current     (input_current),
    .threshold         (threshold),
    .decay_shift       (decay_shift),
    .refractory_period (refractory_period),
    .reset_mode        (reset_mode),
    .busy              (busy),
    .done              (done),
    .spikes_out        (spikes_out),
    .dbg_sel           (dbg_sel),
    .dbg_potential     (dbg_potential)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   spikes;
    logic [N*W-1:0] pots;
    int             lat;
    int             nbusy;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int    tests  = 0;
  int    failed = 0;
  int    mv[N];
  int    mr[N];
  int    cur[N];

  // Reference model: one timestep over all neurons, pushes the expected snapshot.
  task automatic model_step();
    snap_t e;
    int v, lk, nx;
    e = '0;
    for (int n = 0; n < N; n++) begin
      v = mv[n];
      if (v >= int'(threshold)) begin
        e.spikes[n] = 1'b1;
        mv[n] = reset_mode ? 0 : v - int'(threshold);
        mr[n] = int'(refractory_period);
      end else begin
        e.spikes[n] = 1'b0;
        lk = (decay_shift == 0 || int'(decay_shift) >= W) ? 0 : (v >>> decay_shift);
        nx = v - lk + ((mr[n] == 0) ? cur[n] : 0);
        mv[n] = (nx > 15) ? 15 : ((nx < -16) ? -16 : nx);
        if (mr[n] > 0) mr[n] = mr[n] - 1;
      end
      e.pots[n*W +: W] = W'(mv[n]);
    end
    e.lat   = 5;
    e.nbusy = 5;
    exp_q.push_back(e);
  endtask

  task automatic drive_currents();
    for (int n = 0; n < N; n++) input_current[n*W +: W] = W'(cur[n]);
  endtask

  task automatic read_pots(output logic [N*W-1:0] p);
    for (int k = 0; k < N; k++) begin
      dbg_sel = 2'(k);
      #1;
      p[k*W +: W] = dbg_potential;
    end
  endtask

  task automatic set_all(input int i_all);
    for (int n = 0; n < N; n++) cur[n] = i_all;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < N; n++) begin
      mv[n] = 0;
      mr[n] = 0;
    end
  endtask

  // One timestep: expected pushed at stimulus time, observation pushed at done.
  task automatic step(input bit mid_start);
    snap_t o;
    int lat, nbusy;
    o = '0;
    drive_currents();
    model_step();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) nbusy++;
      start = (mid_start && lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy === 1'b1) nbusy++;
    o.spikes = spikes_out;
    read_pots(o.pots);
    o.lat   = lat;
    o.nbusy = nbusy;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    logic [N*W-1:0] p;
    tests++;
    if ({busy, done, spikes_out} !== '0) begin
      failed++;
      $display("FAIL reset_ctrl: busy=%b done=%b spikes=%b, expected all 0", busy, done, spikes_out);
    end
    read_pots(p);
    tests++;
    if (p !== '0) begin
      failed++;
      $display("FAIL reset_pots: got %h, expected 0", p);
    end
  endtask

  task automatic test_latency();
    snap_t e, o;
    do_reset();
    threshold = 5'sd8; decay_shift = 3'd0; refractory_period = '0; reset_mode = 1'b0;
    set_all(3);
    step(1'b1);
    // start while in DONE must not launch another scan
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL start_in_done: busy=%b done=%b, expected 0 0", busy, done);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL latency: got sp=%b pot=%h lat=%0d busy=%0d, expected sp=%b pot=%h lat=%0d busy=%0d",
                 o.spikes, o.pots, o.lat, o.nbusy, e.spikes, e.pots, e.lat, e.nbusy);
      end
    end
  endtask

  task automatic test_integrate_fire();
    snap_t e, o;
    int s;
    do_reset();
    threshold = 5'sd8; decay_shift = 3'd0; refractory_period = '0; reset_mode = 1'b0;
    set_all(3);
    for (int k = 0; k < 5; k++) step(1'b0);
    s = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++; s++;
      if (o !== e) begin
        failed++;
        $display("FAIL integrate step%0d: got sp=%b pot=%h lat=%0d, expected sp=%b pot=%h lat=%0d",
                 s, o.spikes, o.pots, o.lat, e.spikes, e.pots, e.lat);
      end
    end
  endtask

  task automatic test_leak_saturate();
    snap_t e, o;
    int s;
    do_reset();
    threshold = 5'sd15; decay_shift = 3'd1; refractory_period = '0; reset_mode = 1'b0;
    cur[0] = 14; cur[1] = -16; cur[2] = 8; cur[3] = 14;
    step(1'b0);
    step(1'b0);
    cur[2] = 0;
    step(1'b0);
    decay_shift = 3'd7;
    cur[1] = 2;
    step(1'b0);
    s = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++; s++;
      if (o !== e) begin
        failed++;
        $display("FAIL leak_sat step%0d: got sp=%b pot=%h lat=%0d, expected sp=%b pot=%h lat=%0d",
                 s, o.spikes, o.pots, o.lat, e.spikes, e.pots, e.lat);
      end
    end
  endtask

  task automatic test_refractory();
    snap_t e, o;
    int s;
    do_reset();
    threshold = 5'sd4; decay_shift = 3'd0; refractory_period = 5'd2; reset_mode = 1'b0;
    set_all(5);
    for (int k = 0; k < 5; k++) step(1'b0);
    decay_shift = 3'd1;
    for (int k = 0; k < 3; k++) step(1'b0);
    s = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++; s++;
      if (o !== e) begin
        failed++;
        $display("FAIL refractory step%0d: got sp=%b pot=%h lat=%0d, expected sp=%b pot=%h lat=%0d",
                 s, o.spikes, o.pots, o.lat, e.spikes, e.pots, e.lat);
      end
    end
  endtask

  task automatic test_reset_mode();
    snap_t e, o;
    int s;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      threshold = 5'sd8; decay_shift = 3'd0; refractory_period = '0; reset_mode = m[0];
      set_all(3);
      for (int k = 0; k < 4; k++) step(1'b0);
    end
    do_reset();
    threshold = 5'sd4; reset_mode = 1'b0;
    cur[0] = 1; cur[1] = 2; cur[2] = 3; cur[3] = 4;
    for (int k = 0; k < 4; k++) step(1'b0);
    s = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++; s++;
      if (o !== e) begin
        failed++;
        $display("FAIL reset_mode step%0d: got sp=%b pot=%h lat=%0d, expected sp=%b pot=%h lat=%0d",
                 s, o.spikes, o.pots, o.lat, e.spikes, e.pots, e.lat);
      end
    end
  endtask

  task automatic test_async_reset();
    snap_t e, o;
    logic [N*W-1:0] p;
    int s, seen;
    do_reset();
    threshold = 5'sd4; decay_shift = 3'd0; refractory_period = '0; reset_mode = 1'b0;
    set_all(8);
    step(1'b0);
    step(1'b0);
    // abort a scan while neuron 2 is being processed
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({busy, done, spikes_out} !== '0) begin
      failed++;
      $display("FAIL async_reset_ctrl: busy=%b done=%b spikes=%b, expected all 0", busy, done, spikes_out);
    end
    read_pots(p);
    tests++;
    if (p !== '0) begin
      failed++;
      $display("FAIL async_reset_pots: got %h, expected 0", p);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < N; n++) begin
      mv[n] = 0;
      mr[n] = 0;
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      failed++;
      $display("FAIL async_reset_idle: busy/done seen %0d cycles, expected 0", seen);
    end
    step(1'b0);
    s = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++; s++;
      if (o !== e) begin
        failed++;
        $display("FAIL async_reset step%0d: got sp=%b pot=%h lat=%0d, expected sp=%b pot=%h lat=%0d",
                 s, o.spikes, o.pots, o.lat, e.spikes, e.pots, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    snap_t e, o;
    int s;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      threshold         = W'($urandom_range(1, 15));
      decay_shift       = 3'($urandom_range(0, 7));
      refractory_period = RW'($urandom_range(0, 3));
      reset_mode        = 1'($urandom_range(0, 1));
      for (int n = 0; n < N; n++) cur[n] = int'($urandom_range(0, 31)) - 16;
      step(1'b0);
    end
    s = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++; s++;
      if (o !== e) begin
        failed++;
        $display("FAIL random step%0d: got sp=%b pot=%h lat=%0d, expected sp=%b pot=%h lat=%0d",
                 s, o.spikes, o.pots, o.lat, e.spikes, e.pots, e.lat);
      end
    end
  endtask

  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    input_current     = '0;
    threshold         = 5'sd8;
    decay_shift       = 3'd0;
    refractory_period = '0;
    reset_mode        = 1'b0;
    dbg_sel           = '0;
    for (int n = 0; n < N; n++) begin
      mv[n]  = 0;
      mr[n]  = 0;
      cur[n] = 0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_integrate_fire();
    test_leak_saturate();
    test_refractory();
    test_reset_mode();
    test_async_reset();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
